// File: rtl/fringe_sched_pkg.sv
// rtl/fringe_sched_pkg.sv - shared types and defaults for the fringe clock scheduler
package fringe_sched_pkg;

  localparam int N_DEF      = 4;
  localparam int W_DEF      = 9;
  localparam int WD_MAX_DEF = 10000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_GET_REQ,
    S_APPLY,
    S_PUT_REQ,
    S_DONE
  } sched_state_t;

  typedef struct packed {
    logic wd;
    logic ovr;
  } sched_err_t;

endpackage

// File: rtl/fringe_clk_sched_if.sv
// rtl/fringe_clk_sched_if.sv - get/put fringe transport channel shared by all domains
interface fringe_clk_sched_if #(
  parameter int N = 4,
  parameter int W = 9
) ();
  localparam int CW = $clog2(N);

  logic          get_req_o;
  logic [CW-1:0] get_ch_o;
  logic          get_ack_i;
  logic          get_vld_i;
  logic [W-1:0]  get_data_i;
  logic          put_req_o;
  logic [CW-1:0] put_ch_o;
  logic [W-1:0]  put_data_o;
  logic          put_ack_i;

  modport master (
    output get_req_o, get_ch_o, put_req_o, put_ch_o, put_data_o,
    input  get_ack_i, get_vld_i, get_data_i, put_ack_i
  );

  modport slave (
    input  get_req_o, get_ch_o, put_req_o, put_ch_o, put_data_o,
    output get_ack_i, get_vld_i, get_data_i, put_ack_i
  );
endinterface

// File: rtl/fringe_rr_arb.sv
// rtl/fringe_rr_arb.sv - combinational N-way round-robin pick starting after last grant
module fringe_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_pending,
  input  logic [$clog2(N)-1:0] i_last_grant,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);
  localparam int CW = $clog2(N);

  logic [CW-1:0] w_cand;

  // scan farthest-to-nearest so the first pending domain after last_grant wins
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int i = N; i >= 1; i--) begin
      w_cand = CW'((int'(i_last_grant) + i) % N);
      if (i_pending[w_cand]) begin
        o_idx = w_cand;
        o_any = 1'b1;
      end
    end
    if (o_any) o_grant[o_idx] = 1'b1;
  end
endmodule

// File: rtl/fringe_clk_sched.sv
// rtl/fringe_clk_sched.sv - freezes mission-clock domains until their fringe vector is applied
module fringe_clk_sched
  import fringe_sched_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int W      = W_DEF,
  parameter int WD_MAX = WD_MAX_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N-1:0]       edge_i,
  input  logic               get_en_i,
  input  logic               put_en_i,
  output logic [N-1:0]       freeze_clk_o,
  fringe_clk_sched_if.master tp,
  output logic [N-1:0]       apply_o,
  output logic [W-1:0]       apply_data_o,
  input  logic [W-1:0]       sut_data_i,
  output logic               busy_o,
  output logic               wd_err_o,
  output logic               ovr_err_o
);
  localparam int CW  = $clog2(N);
  localparam int WDW = $clog2(WD_MAX + 1);

  sched_state_t   r_state, w_next;
  logic [N-1:0]   r_pending, r_freeze, r_oh;
  logic [CW-1:0]  r_ch, r_last;
  logic [W-1:0]   r_data, r_put_data;
  logic [WDW-1:0] r_wd;
  logic           r_gap;
  sched_err_t     r_err;

  logic [N-1:0]   w_arb_grant;
  logic [CW-1:0]  w_arb_idx;
  logic           w_arb_any;
  logic           w_get_req, w_got, w_wd_abort, w_ovr;
  logic [N-1:0]   w_done_mask, w_rel_mask, w_live, w_accept, w_pend_nxt, w_frz_nxt;

  fringe_rr_arb #(.N(N)) u_arb (
    .i_pending    (r_pending),
    .i_last_grant (r_last),
    .o_grant      (w_arb_grant),
    .o_idx        (w_arb_idx),
    .o_any        (w_arb_any)
  );

  // next-state logic; a poll gap drops the request for one cycle after an invalid ack
  always_comb begin
    w_get_req  = (r_state == S_GET_REQ) && !r_gap;
    w_got      = w_get_req && tp.get_ack_i && tp.get_vld_i;
    w_wd_abort = (r_state == S_GET_REQ) && !w_got && (r_wd == WDW'(WD_MAX - 1));
    w_next     = r_state;
    case (r_state)
      S_IDLE:    if (|r_pending) w_next = S_GRANT;
      S_GRANT: begin
        if (!w_arb_any)    w_next = S_IDLE;
        else if (get_en_i) w_next = S_GET_REQ;
        else if (put_en_i) w_next = S_PUT_REQ;
        else               w_next = S_DONE;
      end
      S_GET_REQ: begin
        if (w_got)           w_next = S_APPLY;
        else if (w_wd_abort) w_next = S_DONE;
      end
      S_APPLY:   w_next = put_en_i ? S_PUT_REQ : S_DONE;
      S_PUT_REQ: if (tp.put_ack_i) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // pending/freeze update: a new edge on the domain finishing in DONE is accepted, not an overrun
  always_comb begin
    w_done_mask = (r_state == S_DONE) ? r_oh : '0;
    w_rel_mask  = ((r_state == S_APPLY) || (r_state == S_DONE) || w_wd_abort) ? r_oh : '0;
    w_live      = r_pending & ~w_done_mask;
    w_accept    = edge_i & ~w_live;
    w_ovr       = |(edge_i & w_live);
    w_pend_nxt  = w_live | w_accept;
    w_frz_nxt   = (r_freeze & ~w_rel_mask) | (get_en_i ? w_accept : '0);
  end

  // state register plus per-transaction datapath
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_freeze   <= '0;
      r_oh       <= '0;
      r_ch       <= '0;
      r_last     <= CW'(N - 1);
      r_data     <= '0;
      r_put_data <= '0;
      r_wd       <= '0;
      r_gap      <= 1'b0;
      r_err      <= '0;
    end else begin
      r_state   <= w_next;
      r_pending <= w_pend_nxt;
      r_freeze  <= w_frz_nxt;
      r_gap     <= w_get_req && tp.get_ack_i && !tp.get_vld_i;
      if (w_ovr)      r_err.ovr <= 1'b1;
      if (w_wd_abort) r_err.wd  <= 1'b1;
      if (r_state == S_GRANT) begin
        r_ch <= w_arb_idx;
        r_oh <= w_arb_grant;
        r_wd <= '0;
      end
      if (r_state == S_GET_REQ) r_wd <= r_wd + 1'b1;
      if (w_got) r_data <= tp.get_data_i;
      if ((w_next == S_PUT_REQ) && (r_state != S_PUT_REQ)) r_put_data <= sut_data_i;
      if (r_state == S_DONE) r_last <= r_ch;
    end
  end

  assign freeze_clk_o  = r_freeze;
  assign tp.get_req_o  = w_get_req;
  assign tp.get_ch_o   = (r_state == S_GET_REQ) ? r_ch : '0;
  assign apply_o       = (r_state == S_APPLY) ? r_oh : '0;
  assign apply_data_o  = (r_state == S_APPLY) ? r_data : '0;
  assign tp.put_req_o  = (r_state == S_PUT_REQ);
  assign tp.put_ch_o   = (r_state == S_PUT_REQ) ? r_ch : '0;
  assign tp.put_data_o = (r_state == S_PUT_REQ) ? r_put_data : '0;
  assign busy_o        = (r_state != S_IDLE);
  assign wd_err_o      = r_err.wd;
  assign ovr_err_o     = r_err.ovr;
endmodule

// File: tb/tb_fringe_clk_sched.sv
// tb/tb_fringe_clk_sched.sv - scoreboard bench for fringe_clk_sched
module tb_fringe_clk_sched;
  localparam int N  = 4;
  localparam int W  = 9;
  localparam int WD = 16;

  typedef struct packed { logic [N-1:0] oh; logic [W-1:0] data; } app_t;
  typedef struct packed { logic [1:0] ch; logic [W-1:0] data; } put_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] edge_v = '0;
  logic         get_en = 1'b1;
  logic         put_en = 1'b1;
  logic [N-1:0] freeze, apply;
  logic [W-1:0] apply_data;
  logic [W-1:0] sut_data = '0;
  logic         busy, wd_err, ovr_err;

  app_t q_app[$];
  put_t q_put[$];
  app_t e_app;
  put_t e_put;
  logic [W-1:0] dat [N];

  int errors = 0;
  int checks = 0;
  int frz_cycles = 0, req_cycles = 0, req_rises = 0;
  int cfg_wait = 0, cfg_invalid = 0;
  bit cfg_noack = 1'b0;
  int r_wait = 0, r_poll = 0;
  logic m_prev_req = 1'b0, m_prev_put = 1'b0;

  fringe_clk_sched_if #(.N(N), .W(W)) tp ();

  fringe_clk_sched #(.N(N), .W(W), .WD_MAX(WD)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .edge_i       (edge_v),
    .get_en_i     (get_en),
    .put_en_i     (put_en),
    .freeze_clk_o (freeze),
    .tp           (tp),
    .apply_o      (apply),
    .apply_data_o (apply_data),
    .sut_data_i   (sut_data),
    .busy_o       (busy),
    .wd_err_o     (wd_err),
    .ovr_err_o    (ovr_err)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_apply(int ch, logic [W-1:0] d);
    app_t a;
    a.oh   = 4'(1 << ch);
    a.data = d;
    q_app.push_back(a);
  endtask

  task automatic exp_put(int ch, logic [W-1:0] d);
    put_t p;
    p.ch   = 2'(ch);
    p.data = d;
    q_put.push_back(p);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    edge_v = '0;
    r_wait = 0;
    r_poll = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse(logic [N-1:0] m);
    @(negedge clk);
    edge_v = m;
    @(negedge clk);
    edge_v = '0;
  endtask

  task automatic wait_done(string name);
    int n = 0;
    repeat (2) @(negedge clk);
    while ((busy || q_app.size() != 0 || q_put.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_in_time"}, int'(n < 400), 1);
  endtask

  // transport model: ack after cfg_wait cycles, first cfg_invalid acks carry no data
  initial begin : responder
    tp.get_ack_i  = 1'b0;
    tp.get_vld_i  = 1'b0;
    tp.get_data_i = '0;
    tp.put_ack_i  = 1'b0;
    forever begin
      @(negedge clk);
      tp.get_ack_i  = 1'b0;
      tp.get_vld_i  = 1'b0;
      tp.get_data_i = '0;
      tp.put_ack_i  = tp.put_req_o;
      if (tp.get_req_o && !cfg_noack) begin
        if (r_wait < cfg_wait) begin
          r_wait++;
        end else begin
          r_wait = 0;
          tp.get_ack_i = 1'b1;
          if (r_poll < cfg_invalid) begin
            r_poll++;
          end else begin
            r_poll        = 0;
            tp.get_vld_i  = 1'b1;
            tp.get_data_i = dat[tp.get_ch_o];
          end
        end
      end else begin
        r_wait = 0;
      end
    end
  end

  // monitor: pops expected apply/put entries whenever the DUT presents one
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (freeze != '0) frz_cycles++;
      if (tp.get_req_o) req_cycles++;
      if (tp.get_req_o && !m_prev_req) req_rises++;
      m_prev_req = tp.get_req_o;
      if (apply != '0) begin
        if (q_app.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL apply_unexpected: got apply=%b data=%h expected none", apply, apply_data);
        end else begin
          e_app = q_app.pop_front();
          check("apply_onehot", int'(apply), int'(e_app.oh));
          check("apply_data", int'(apply_data), int'(e_app.data));
        end
      end
      if (tp.put_req_o && !m_prev_put) begin
        if (q_put.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL put_unexpected: got ch=%0d data=%h expected none", tp.put_ch_o, tp.put_data_o);
        end else begin
          e_put = q_put.pop_front();
          check("put_ch", int'(tp.put_ch_o), int'(e_put.ch));
          check("put_data", int'(tp.put_data_o), int'(e_put.data));
        end
      end
      m_prev_put = tp.put_req_o;
    end
  end

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    dat[0] = 9'h011;
    dat[1] = 9'h122;
    dat[2] = 9'h1A5;
    dat[3] = 9'h033;
    repeat (3) @(negedge clk);
    check("rst_freeze", int'(freeze), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_get_req", int'(tp.get_req_o), 0);
    check("rst_apply", int'(apply), 0);
    check("rst_put_req", int'(tp.put_req_o), 0);
    check("rst_errs", int'({wd_err, ovr_err}), 0);
    rst_n = 1'b1;

    // single domain 2: req held two cycles, freeze spans edge+1 .. apply
    sut_data   = 9'h0C3;
    cfg_wait   = 1;
    frz_cycles = 0;
    req_cycles = 0;
    exp_apply(2, 9'h1A5);
    exp_put(2, 9'h0C3);
    pulse(4'b0100);
    wait_done("t1");
    check("t1_freeze_cycles", frz_cycles, 5);
    check("t1_req_cycles", req_cycles, 2);

    // fresh round robin: 0,1,3; then 0 alone; then {0,1} after grant 0 -> 1,0
    do_reset();
    cfg_wait = 0;
    sut_data = 9'h155;
    exp_apply(0, 9'h011); exp_put(0, 9'h155);
    exp_apply(1, 9'h122); exp_put(1, 9'h155);
    exp_apply(3, 9'h033); exp_put(3, 9'h155);
    pulse(4'b1011);
    wait_done("t2a");
    exp_apply(0, 9'h011); exp_put(0, 9'h155);
    pulse(4'b0001);
    wait_done("t2b");
    exp_apply(1, 9'h122); exp_put(1, 9'h155);
    exp_apply(0, 9'h011); exp_put(0, 9'h155);
    pulse(4'b0011);
    wait_done("t2c");

    // three invalid polls before valid data, no put
    cfg_invalid = 3;
    put_en      = 1'b0;
    req_rises   = 0;
    exp_apply(1, 9'h122);
    pulse(4'b0010);
    wait_done("t3");
    check("t3_get_reissues", req_rises - 1, 3);
    check("t3_no_wd", int'(wd_err), 0);
    cfg_invalid = 0;

    // watchdog: never ack, request held WD cycles then abort
    cfg_noack  = 1'b1;
    put_en     = 1'b1;
    req_cycles = 0;
    pulse(4'b1000);
    wait_done("t4");
    check("t4_req_cycles", req_cycles, WD);
    check("t4_wd_err", int'(wd_err), 1);
    check("t4_freeze_released", int'(freeze), 0);
    check("t4_idle", int'(busy), 0);
    cfg_noack = 1'b0;

    // overrun: second edge on still-pending domain 1
    do_reset();
    cfg_wait = 3;
    put_en   = 1'b0;
    exp_apply(1, 9'h122);
    pulse(4'b0010);
    pulse(4'b0010);
    wait_done("t5a");
    check("t5a_ovr", int'(ovr_err), 1);

    // edge landing in DONE of domain 1 is re-serviced without overrun
    do_reset();
    cfg_wait = 0;
    exp_apply(1, 9'h122);
    exp_apply(1, 9'h122);
    pulse(4'b0010);
    n = 0;
    while (!apply[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5b_apply_seen", int'(apply[1]), 1);
    @(negedge clk);
    edge_v = 4'b0010;
    @(negedge clk);
    edge_v = '0;
    wait_done("t5b");
    check("t5b_no_ovr", int'(ovr_err), 0);

    // reset asserted while fetching
    cfg_noack = 1'b1;
    put_en    = 1'b1;
    pulse(4'b0001);
    n = 0;
    while (!tp.get_req_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_req_seen", int'(tp.get_req_o), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_outs_zero", int'({freeze, tp.get_req_o, apply, tp.put_req_o, busy}), 0);
    rst_n     = 1'b1;
    cfg_noack = 1'b0;

    // fetch disabled: no freeze, no get, put only
    get_en     = 1'b0;
    sut_data   = 9'h0AA;
    frz_cycles = 0;
    req_rises  = 0;
    exp_put(2, 9'h0AA);
    pulse(4'b0100);
    wait_done("t7");
    check("t7_no_freeze", frz_cycles, 0);
    check("t7_no_get", req_rises, 0);
    get_en = 1'b1;

    repeat (3) @(negedge clk);
    check("end_q_apply", q_app.size(), 0);
    check("end_q_put", q_put.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
